// File: rtl/memory_bus_pkg.sv
// -----------------------------------------------------------------------------
// memory_bus_pkg
//   Shared types and helpers for the memory bus interconnect blocks.
//   - mem_req_t / mem_rsp_t : request and response payloads at the default
//                             bus widths, for blocks and benches that use the
//                             standard configuration.
//   - port_bits()           : width of a port index for a given port count.
//   No ports (package).
// -----------------------------------------------------------------------------
package memory_bus_pkg;

    localparam int DEFAULT_NUM_MASTERS   = 4;
    localparam int DEFAULT_DATA_WIDTH    = 24;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_ID_WIDTH      = 8;

    typedef struct packed {
        logic [DEFAULT_ID_WIDTH-1:0]      id;
        logic [DEFAULT_ADDRESS_WIDTH-1:0] address;
        logic [DEFAULT_DATA_WIDTH-1:0]    data;
        logic                             write;
    } mem_req_t;

    typedef struct packed {
        logic [DEFAULT_ID_WIDTH-1:0]   id;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } mem_rsp_t;

    // A single port still needs one index bit so vectors never collapse to
    // zero width.
    function automatic int port_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant: picks the first asserted request found
//   when searching upward from ptr, wrapping from NUM_REQ-1 back to 0.
//   Ports:
//     req   in  NUM_REQ    request vector
//     ptr   in  PTR_WIDTH  highest-priority index (expected < NUM_REQ)
//     grant out NUM_REQ    one-hot grant, all-zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable written here gets a value before any branch,
        // otherwise paths that skip the assignment would infer latches.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modulo keeps the search inside the port range even for
            // non-power-of-two port counts.
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter
//   N-to-1 registered request merge with round-robin priority, plus a
//   zero-latency response router keyed on a slice of the response ID.
//   Ports:
//     clock, reset                      clock (rising edge), async active-low reset
//     usID/usAddress/usData/usWrite/usValid  in   per-master requests
//     usTaken                           out  per-master request accept
//     suID/suData/suValid               out  per-master responses
//     suTaken                           in   per-master response accept
//     mmsID/mmsAddress/mmsData/mmsWrite/mmsValid  out  downstream request
//     mmsTaken                          in   downstream request accept
//     msmID/msmData/msmValid            in   downstream response
//     msmTaken                          out  downstream response accept
//     routeError                        out  sticky: misrouted response dropped
// -----------------------------------------------------------------------------
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 8,
    parameter int PORT_SEL_LSB    = 2
) (
    input  logic                                            clock,
    input  logic                                            reset,

    input  logic [NUM_MASTERS-1:0][MASTER_ID_WIDTH-1:0]     usID,
    input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]       usAddress,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]          usData,
    input  logic [NUM_MASTERS-1:0]                          usWrite,
    input  logic [NUM_MASTERS-1:0]                          usValid,
    output logic [NUM_MASTERS-1:0]                          usTaken,

    output logic [NUM_MASTERS-1:0][MASTER_ID_WIDTH-1:0]     suID,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]          suData,
    output logic [NUM_MASTERS-1:0]                          suValid,
    input  logic [NUM_MASTERS-1:0]                          suTaken,

    output logic [MASTER_ID_WIDTH-1:0]                      mmsID,
    output logic [ADDRESS_WIDTH-1:0]                        mmsAddress,
    output logic [DATA_WIDTH-1:0]                           mmsData,
    output logic                                            mmsWrite,
    output logic                                            mmsValid,
    input  logic                                            mmsTaken,

    input  logic [MASTER_ID_WIDTH-1:0]                      msmID,
    input  logic [DATA_WIDTH-1:0]                           msmData,
    input  logic                                            msmValid,
    output logic                                            msmTaken,

    output logic                                            routeError
);

    localparam int PORT_BITS = port_bits(NUM_MASTERS);
    localparam logic [PORT_BITS:0] PORT_LIMIT = NUM_MASTERS[PORT_BITS:0];

    typedef struct packed {
        logic [MASTER_ID_WIDTH-1:0] id;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [DATA_WIDTH-1:0]      data;
        logic                       write;
    } req_word_t;

    // ---------------------------------------------------------------- request
    logic [PORT_BITS-1:0]   ptr;
    logic [PORT_BITS-1:0]   ptr_next;
    logic [PORT_BITS-1:0]   grant_idx;
    logic [NUM_MASTERS-1:0] grant;
    logic                   granted;
    logic                   accept;
    logic                   full;
    req_word_t              sel_req;
    req_word_t              held_req;

    rr_arbiter #(
        .NUM_REQ   (NUM_MASTERS),
        .PTR_WIDTH (PORT_BITS)
    ) u_rr_arbiter (
        .req   (usValid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_req   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                grant_idx = i[PORT_BITS-1:0];
                sel_req   = '{id:      usID[i],
                              address: usAddress[i],
                              data:    usData[i],
                              write:   usWrite[i]};
            end
        end
        granted  = |grant;
        // Gating with reset keeps usTaken low while reset is held, so no
        // master believes a request was consumed that the register discards.
        accept   = reset && (!full || mmsTaken);
        usTaken  = accept ? grant : '0;
        ptr_next = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;
    end

    // The held request is part of the visible bus state, so it is reset too:
    // mms* payload reads as zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            full     <= 1'b0;
            held_req <= '0;
            ptr      <= '0;
        end else if (accept && granted) begin
            // Covers the drain-and-reload case: full stays set.
            full     <= 1'b1;
            held_req <= sel_req;
            ptr      <= ptr_next;
        end else if (mmsTaken) begin
            full     <= 1'b0;
        end
    end

    assign mmsID      = held_req.id;
    assign mmsAddress = held_req.address;
    assign mmsData    = held_req.data;
    assign mmsWrite   = held_req.write;
    assign mmsValid   = full;

    // --------------------------------------------------------------- response
    logic [PORT_BITS-1:0] rsp_port;
    logic                 rsp_in_range;

    assign rsp_port     = msmID[PORT_SEL_LSB +: PORT_BITS];
    assign rsp_in_range = {1'b0, rsp_port} < PORT_LIMIT;

    always_comb begin
        suValid  = '0;
        // Out-of-range responses are swallowed so the memory side never
        // deadlocks on a port that does not exist.
        msmTaken = !rsp_in_range;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            suID[i]   = msmID;
            suData[i] = msmData;
            if (rsp_in_range && rsp_port == i[PORT_BITS-1:0]) begin
                suValid[i] = msmValid;
                msmTaken   = suTaken[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            routeError <= 1'b0;
        end else if (msmValid && !rsp_in_range) begin
            routeError <= 1'b1;
        end
    end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Parametrised N-to-1 memory bus arbiter that merges the request channels of `NUM_MASTERS` bus masters (ray tracer cores, config DMA, frame readers) onto one downstream memory bus and routes returned read data back to the owning master by ID. It generalises the single-master flat-port bus wrapping used around the ray tracer into a multi-channel, round-robin, registered interconnect stage. It sits between the master cluster and the memory controller.

## Interface
- `NUM_MASTERS`, 4: number of upstream master ports, ≥2.
- `DATA_WIDTH`, 24: bus data width.
- `ADDRESS_WIDTH`, 32: bus address width.
- `MASTER_ID_WIDTH`, 8: ID field width.
- `PORT_SEL_LSB`, 2: LSB of the ID bits selecting the response port; `PORT_BITS = $clog2(NUM_MASTERS)`.

Ports (bundles `[NUM_MASTERS-1:0]` packed arrays):
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `usID / usAddress / usData / usWrite / usValid`  in  N×field  upstream requests.
- `usTaken`  out  N  per-port request accept.
- `suID / suData / suValid`  out  N×field  responses to masters.
- `suTaken`  in  N  per-port response accept.
- `mmsID / mmsAddress / mmsData / mmsWrite / mmsValid`  out  field  downstream request.
- `mmsTaken`  in  1  downstream request accept.
- `msmID / msmData / msmValid`  in  field  downstream response.
- `msmTaken`  out  1  downstream response accept.
- `routeError`  out  1  sticky: response with out-of-range port index dropped.

## Operation
- Handshake: a transfer occurs on a cycle where valid && taken, both sides.
- Request path: one-entry output register (`full` flag) driving `mms*`. `accept = !full || mmsTaken`.
- Round-robin: priority pointer `ptr` (PORT_BITS). Grant = first `usValid[i]` searching from `ptr` upward, wrapping at `NUM_MASTERS-1` → 0. `usTaken[i] = accept && grant==i`, at most one bit set; zero when no `usValid`.
- On accept with a grant: register loads granted request, `full`←1, `ptr`←grant+1 (wrap). On `mmsTaken` without new grant: `full`←0. Pointer unchanged when nothing granted.
- ID, address, data, write forwarded unmodified.
- Response path (combinational, no storage): `p = msmID[PORT_SEL_LSB +: PORT_BITS]`. If `p < NUM_MASTERS`: `suValid[p] = msmValid`, `msmTaken = suTaken[p]`, other `suValid` 0. Else: `msmTaken = 1`, response dropped, `routeError`←1 on that handshake.
- `suID/suData` for all ports driven from `msmID/msmData` (valid-qualified only).
- Reset (async assert, sync release): `full`=0, `mmsValid`=0, `ptr`=0, `routeError`=0, all `mms*` payload 0, `usTaken`=0. Reset mid-transfer discards held request.

## Timing
- Request latency: granted at cycle t → `mmsValid` high at t+1; sustained throughput one request/cycle while `mmsTaken` held high.
- `usTaken` depends combinationally on `usValid`, `full`, `mmsTaken`; no dependency on `usTaken`→`usValid` loops.
- Stall: `mmsValid` held with stable payload until `mmsTaken`; `usTaken` all-zero while full and not taken.
- Simultaneous drain and grant: register reloads same cycle, `full` stays 1.
- Response latency 0 cycles; backpressure passes straight through.
- `routeError` rises the cycle after the dropping handshake; clears only on reset.

## Structure
- `memory_bus_pkg`: request struct (`id`, `address`, `data`, `write`), response struct (`id`, `data`), parametrised-width helper `PORT_BITS` function.
- One sub-module: `rr_arbiter` (N requests, pointer in, one-hot grant out, combinational), reused by future interconnect blocks.

## Test plan
- Single master: port 2 sends addr 0x100 write data 0xABCDEF, `mmsTaken`=1 → `mms*` carries it at t+1, `usTaken[2]` high one cycle.
- All 4 ports valid continuously, `mmsTaken`=1 → grant order 0,1,2,3,0… with one request per cycle, `ptr` wraps.
- `mmsTaken`=0 for 5 cycles with port 1 valid → `mmsValid` held, payload stable, `usTaken`=0; release → next grant same cycle drain.
- Response `msmID`=0x0C (p=3), `suTaken[3]`=0 then 1 → `suValid[3]` only, `msmTaken` follows `suTaken[3]`; data delivered once.
- `NUM_MASTERS`=3, response ID with p=3 → `msmTaken`=1, no `suValid`, `routeError`=1 next cycle, stays until reset.
- Assert `reset` low while `full`=1 → `mmsValid`=0 immediately, `ptr`=0 after release, arbitration restarts at port 0.
